// File: rtl/key_cmd_gen_if.sv
// Command stream between the key command generator and its consumer.
//   cmd_valid  - FIFO holds at least one command
//   cmd_code   - key index at the FIFO head (0 up, 1 down, 2 left, 3 right, 4 restart)
//   cmd_ready  - consumer accepts the head when cmd_valid && cmd_ready
//   cmd_level  - current FIFO occupancy, 0..4
//   overflow   - sticky: a command was dropped because the FIFO was full
// master: the generator side; slave: the consumer side.
interface key_cmd_gen_if;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_ready;
    logic [2:0] cmd_level;
    logic       overflow;

    modport master (
        output cmd_valid,
        output cmd_code,
        output cmd_level,
        output overflow,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_code,
        input  cmd_level,
        input  overflow,
        output cmd_ready
    );
endinterface

// File: rtl/key_cmd_gen.sv
// Key command generator: turns a debounced 5-key bus into a stream of key
// commands with auto-repeat, buffered in a 4-entry FIFO.
//   clk_1ms - 1 ms clock, all logic on its rising edge
//   rst     - asynchronous active-high reset
//   pbreg   - debounced key bus; bit k low means key k held (all-0 / all-1 = no key)
//   cmd     - command stream (master modport of key_cmd_gen_if)
// DELAY_MS  - ticks from a press to its first auto-repeat
// PERIOD_MS - ticks between successive auto-repeats
module key_cmd_gen #(
    parameter int unsigned DELAY_MS  = 400,
    parameter int unsigned PERIOD_MS = 150
) (
    input  logic          clk_1ms,
    input  logic          rst,
    input  logic [4:0]    pbreg,
    key_cmd_gen_if.master cmd
);

    localparam logic [9:0] DelayLast  = 10'(DELAY_MS - 1);
    localparam logic [9:0] PeriodLast = 10'(PERIOD_MS - 1);
    localparam logic [2:0] KeyRestart = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StHoldDelay,
        StHoldRepeat
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [2:0] held_q, held_d;

    logic [2:0] mem_q [4];
    logic [2:0] mem_d [4];
    logic [1:0] wr_q, wr_d;
    logic [1:0] rd_q, rd_d;
    logic [2:0] level_q, level_d;
    logic       ovf_q, ovf_d;

    logic       key_hit;
    logic [2:0] key_idx;
    logic       push;
    logic [2:0] push_code;
    logic       pop;
    logic       full;
    logic       wr_en;

    // Key decode: lowest cleared bit wins.
    always_comb begin
        key_hit = 1'b0;
        key_idx = 3'd0;
        if (pbreg != 5'b00000 && pbreg != 5'b11111) begin
            for (int k = 4; k >= 0; k--) begin
                if (!pbreg[k]) begin
                    key_hit = 1'b1;
                    key_idx = 3'(k);
                end
            end
        end
    end

    // Hold / auto-repeat sequencing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        held_d    = held_q;
        push      = 1'b0;
        push_code = held_q;
        unique case (state_q)
            StIdle: begin
                if (key_hit) begin
                    push      = 1'b1;
                    push_code = key_idx;
                    held_d    = key_idx;
                    cnt_d     = 10'd0;
                    state_d   = StHoldDelay;
                end
            end
            StHoldDelay, StHoldRepeat: begin
                if (!key_hit) begin
                    cnt_d   = 10'd0;
                    state_d = StIdle;
                end else if (key_idx != held_q) begin
                    // A different key is a fresh press.
                    push      = 1'b1;
                    push_code = key_idx;
                    held_d    = key_idx;
                    cnt_d     = 10'd0;
                    state_d   = StHoldDelay;
                end else if (state_q == StHoldDelay) begin
                    if (cnt_q == DelayLast) begin
                        // Restart never repeats: counter parks here until release.
                        if (held_q != KeyRestart) begin
                            push    = 1'b1;
                            cnt_d   = 10'd0;
                            state_d = StHoldRepeat;
                        end
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end else begin
                    if (cnt_q == PeriodLast) begin
                        push  = 1'b1;
                        cnt_d = 10'd0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            default: begin
                cnt_d   = 10'd0;
                state_d = StIdle;
            end
        endcase
    end

    // FIFO: a pop frees the head slot in the same edge, so a push into a full
    // FIFO is accepted when it coincides with a pop.
    always_comb begin
        pop     = (level_q != 3'd0) && cmd.cmd_ready;
        full    = (level_q == 3'd4);
        wr_en   = push && (!full || pop);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        if (wr_en) begin
            mem_d[wr_q] = push_code;
            wr_d        = wr_q + 2'd1;
        end
        if (pop) begin
            rd_d = rd_q + 2'd1;
        end
        if (wr_en && !pop) begin
            level_d = level_q + 3'd1;
        end else if (pop && !wr_en) begin
            level_d = level_q - 3'd1;
        end
        if (push && !wr_en) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_1ms or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 10'd0;
            held_q  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 3'd0;
            end
            wr_q    <= 2'd0;
            rd_q    <= 2'd0;
            level_q <= 3'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cmd.cmd_valid = (level_q != 3'd0);
    assign cmd.cmd_code  = (level_q != 3'd0) ? mem_q[rd_q] : 3'd0;
    assign cmd.cmd_level = level_q;
    assign cmd.overflow  = ovf_q;

endmodule

// File: tb/tb_key_cmd_gen.sv
// Self-checking bench for key_cmd_gen. Expected commands are queued when a
// press is driven; a monitor records every accepted command (code + edge
// number) and each test drains those records against the expected queue.
module tb_key_cmd_gen;

    typedef struct {
        logic [2:0] code;
        int         cyc;   // edge number the command must be accepted after, -1 = any
    } exp_t;

    logic       clk_1ms = 1'b0;
    logic       rst     = 1'b1;
    logic [4:0] pbreg   = 5'b00000;

    key_cmd_gen_if cmd_if ();

    key_cmd_gen #(
        .DELAY_MS  (400),
        .PERIOD_MS (150)
    ) dut (
        .clk_1ms (clk_1ms),
        .rst     (rst),
        .pbreg   (pbreg),
        .cmd     (cmd_if)
    );

    always #5 clk_1ms = ~clk_1ms;

    int cyc = 0;
    always @(posedge clk_1ms) cyc <= cyc + 1;

    // Accepted-command recorder.
    logic [2:0] obs_code [256];
    int         obs_cyc  [256];
    int         obs_wr = 0;
    int         obs_rd = 0;

    always @(negedge clk_1ms) begin
        #1;
        if (!rst && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            obs_code[obs_wr % 256] <= cmd_if.cmd_code;
            obs_cyc[obs_wr % 256]  <= cyc;
            obs_wr                 <= obs_wr + 1;
        end
    end

    exp_t exp_q [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk_1ms);
    endtask

    task automatic press(input logic [4:0] pat, input int hold, input int gap);
        pbreg = pat;
        wait_edges(hold);
        pbreg = 5'b00000;
        wait_edges(gap);
    endtask

    task automatic test_reset;
        cmd_if.cmd_ready = 1'b0;
        rst = 1'b1;
        wait_edges(3);
        n_vec++;
        if ({cmd_if.cmd_valid, cmd_if.cmd_code, cmd_if.cmd_level, cmd_if.overflow} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b code=%0d lvl=%0d ovf=%b, required all 0",
                     cmd_if.cmd_valid, cmd_if.cmd_code, cmd_if.cmd_level, cmd_if.overflow);
        end
        rst = 1'b0;
        cmd_if.cmd_ready = 1'b1;   // ready while empty must do nothing
        wait_edges(4);
        n_vec++;
        if (cmd_if.cmd_level !== 3'd0 || cmd_if.cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ready_when_empty: got lvl=%0d v=%b, required 0 0",
                     cmd_if.cmd_level, cmd_if.cmd_valid);
        end
        cmd_if.cmd_ready = 1'b0;
    endtask

    task automatic test_single_press;
        exp_t e;
        cmd_if.cmd_ready = 1'b0;
        exp_q.push_back('{code: 3'd2, cyc: -1});
        press(5'b11011, 3, 10);
        n_vec++;
        if (cmd_if.cmd_level !== 3'd1 || cmd_if.cmd_code !== 3'd2 || cmd_if.cmd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL single_press: got lvl=%0d code=%0d v=%b, required 1 2 1",
                     cmd_if.cmd_level, cmd_if.cmd_code, cmd_if.cmd_valid);
        end
        cmd_if.cmd_ready = 1'b1;
        wait_edges(3);
        cmd_if.cmd_ready = 1'b0;
        while (obs_rd < obs_wr) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL single_press_extra: got code %0d, required none", obs_code[obs_rd % 256]);
            end else begin
                e = exp_q.pop_front();
                if (obs_code[obs_rd % 256] !== e.code) begin
                    n_err++;
                    $display("FAIL single_press_code: got %0d, required %0d", obs_code[obs_rd % 256], e.code);
                end
            end
            obs_rd++;
        end
        n_vec++;
        if (exp_q.size() != 0 || cmd_if.cmd_level !== 3'd0) begin
            n_err++;
            $display("FAIL single_press_drain: got %0d missing lvl=%0d, required 0 0",
                     exp_q.size(), cmd_if.cmd_level);
        end
    endtask

    task automatic test_auto_repeat;
        exp_t e;
        int   edge_e;
        cmd_if.cmd_ready = 1'b1;
        edge_e = cyc + 1;
        exp_q.push_back('{code: 3'd0, cyc: edge_e});
        exp_q.push_back('{code: 3'd0, cyc: edge_e + 400});
        exp_q.push_back('{code: 3'd0, cyc: edge_e + 550});
        exp_q.push_back('{code: 3'd0, cyc: edge_e + 700});
        press(5'b11110, 800, 5);
        while (obs_rd < obs_wr) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL repeat_extra: got code %0d at edge %0d, required none",
                         obs_code[obs_rd % 256], obs_cyc[obs_rd % 256]);
            end else begin
                e = exp_q.pop_front();
                if (obs_code[obs_rd % 256] !== e.code || obs_cyc[obs_rd % 256] != e.cyc) begin
                    n_err++;
                    $display("FAIL repeat_cmd: got code %0d at edge %0d, required code %0d at edge %0d",
                             obs_code[obs_rd % 256], obs_cyc[obs_rd % 256], e.code, e.cyc);
                end
            end
            obs_rd++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL repeat_missing: got %0d commands missing, required 0", exp_q.size());
            exp_q.delete();
        end
        cmd_if.cmd_ready = 1'b0;
    endtask

    task automatic test_restart_no_repeat;
        exp_t e;
        cmd_if.cmd_ready = 1'b1;
        exp_q.push_back('{code: 3'd4, cyc: cyc + 1});
        press(5'b01111, 1000, 5);
        while (obs_rd < obs_wr) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL restart_extra: got code %0d at edge %0d, required none",
                         obs_code[obs_rd % 256], obs_cyc[obs_rd % 256]);
            end else begin
                e = exp_q.pop_front();
                if (obs_code[obs_rd % 256] !== e.code || obs_cyc[obs_rd % 256] != e.cyc) begin
                    n_err++;
                    $display("FAIL restart_cmd: got code %0d at edge %0d, required code %0d at edge %0d",
                             obs_code[obs_rd % 256], obs_cyc[obs_rd % 256], e.code, e.cyc);
                end
            end
            obs_rd++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL restart_missing: got %0d missing, required 0", exp_q.size());
            exp_q.delete();
        end
        cmd_if.cmd_ready = 1'b0;
    endtask

    task automatic test_overflow;
        exp_t       e;
        logic [4:0] pat;
        cmd_if.cmd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            pat = ~(5'b00001 << k);
            if (k < 4) exp_q.push_back('{code: 3'(k), cyc: -1});
            press(pat, 2, 2);
        end
        n_vec++;
        if (cmd_if.cmd_level !== 3'd4 || cmd_if.overflow !== 1'b1 || cmd_if.cmd_code !== 3'd0) begin
            n_err++;
            $display("FAIL overflow_full: got lvl=%0d ovf=%b head=%0d, required 4 1 0",
                     cmd_if.cmd_level, cmd_if.overflow, cmd_if.cmd_code);
        end
        cmd_if.cmd_ready = 1'b1;
        wait_edges(6);
        cmd_if.cmd_ready = 1'b0;
        while (obs_rd < obs_wr) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL overflow_extra: got code %0d, required none", obs_code[obs_rd % 256]);
            end else begin
                e = exp_q.pop_front();
                if (obs_code[obs_rd % 256] !== e.code) begin
                    n_err++;
                    $display("FAIL overflow_order: got %0d, required %0d", obs_code[obs_rd % 256], e.code);
                end
            end
            obs_rd++;
        end
        n_vec++;
        if (exp_q.size() != 0 || cmd_if.cmd_level !== 3'd0 || cmd_if.overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_drain: got missing=%0d lvl=%0d ovf=%b, required 0 0 1",
                     exp_q.size(), cmd_if.cmd_level, cmd_if.overflow);
            exp_q.delete();
        end
    endtask

    task automatic test_full_push_pop;
        exp_t e;
        rst = 1'b1;
        wait_edges(2);
        rst = 1'b0;
        obs_rd = obs_wr;
        cmd_if.cmd_ready = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            exp_q.push_back('{code: 3'(k), cyc: -1});
            press(~(5'b00001 << k), 2, 2);
        end
        n_vec++;
        if (cmd_if.cmd_level !== 3'd4 || cmd_if.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_fill: got lvl=%0d ovf=%b, required 4 0", cmd_if.cmd_level, cmd_if.overflow);
        end
        // Pop and push on the same edge while full.
        cmd_if.cmd_ready = 1'b1;
        pbreg = 5'b01111;
        exp_q.push_back('{code: 3'd4, cyc: -1});
        @(negedge clk_1ms);
        cmd_if.cmd_ready = 1'b0;
        pbreg = 5'b00000;
        #2;
        n_vec++;
        if (cmd_if.cmd_level !== 3'd4 || cmd_if.overflow !== 1'b0 || cmd_if.cmd_code !== 3'd2) begin
            n_err++;
            $display("FAIL full_push_pop: got lvl=%0d ovf=%b head=%0d, required 4 0 2",
                     cmd_if.cmd_level, cmd_if.overflow, cmd_if.cmd_code);
        end
        wait_edges(2);
        cmd_if.cmd_ready = 1'b1;
        wait_edges(6);
        cmd_if.cmd_ready = 1'b0;
        while (obs_rd < obs_wr) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL full_extra: got code %0d, required none", obs_code[obs_rd % 256]);
            end else begin
                e = exp_q.pop_front();
                if (obs_code[obs_rd % 256] !== e.code) begin
                    n_err++;
                    $display("FAIL full_order: got %0d, required %0d", obs_code[obs_rd % 256], e.code);
                end
            end
            obs_rd++;
        end
        n_vec++;
        if (exp_q.size() != 0 || cmd_if.cmd_level !== 3'd0) begin
            n_err++;
            $display("FAIL full_drain: got missing=%0d lvl=%0d, required 0 0", exp_q.size(), cmd_if.cmd_level);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_hold;
        exp_t e;
        cmd_if.cmd_ready = 1'b0;
        pbreg = 5'b11101;
        exp_q.push_back('{code: 3'd1, cyc: -1});
        wait_edges(200);
        pbreg = 5'b11100;
        exp_q.push_back('{code: 3'd0, cyc: -1});
        wait_edges(5);
        n_vec++;
        if (cmd_if.cmd_level !== 3'd2 || cmd_if.cmd_code !== 3'd1) begin
            n_err++;
            $display("FAIL mid_hold_change: got lvl=%0d head=%0d, required 2 1",
                     cmd_if.cmd_level, cmd_if.cmd_code);
        end
        // Assert reset mid-hold with the consumer trying to pop.
        cmd_if.cmd_ready = 1'b1;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({cmd_if.cmd_valid, cmd_if.cmd_code, cmd_if.cmd_level, cmd_if.overflow} !== 8'h00) begin
            n_err++;
            $display("FAIL mid_hold_reset: got v=%b code=%0d lvl=%0d ovf=%b, required all 0",
                     cmd_if.cmd_valid, cmd_if.cmd_code, cmd_if.cmd_level, cmd_if.overflow);
        end
        cmd_if.cmd_ready = 1'b0;
        exp_q.delete();
        wait_edges(3);
        obs_rd = obs_wr;
        rst = 1'b0;
        exp_q.push_back('{code: 3'd0, cyc: -1});
        @(negedge clk_1ms);
        n_vec++;
        if (cmd_if.cmd_level !== 3'd1 || cmd_if.cmd_code !== 3'd0 || cmd_if.cmd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_press: got lvl=%0d code=%0d v=%b, required 1 0 1",
                     cmd_if.cmd_level, cmd_if.cmd_code, cmd_if.cmd_valid);
        end
        cmd_if.cmd_ready = 1'b1;
        wait_edges(3);
        cmd_if.cmd_ready = 1'b0;
        pbreg = 5'b00000;
        wait_edges(2);
        while (obs_rd < obs_wr) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL post_reset_extra: got code %0d, required none", obs_code[obs_rd % 256]);
            end else begin
                e = exp_q.pop_front();
                if (obs_code[obs_rd % 256] !== e.code) begin
                    n_err++;
                    $display("FAIL post_reset_code: got %0d, required %0d", obs_code[obs_rd % 256], e.code);
                end
            end
            obs_rd++;
        end
        n_vec++;
        if (exp_q.size() != 0 || cmd_if.cmd_level !== 3'd0) begin
            n_err++;
            $display("FAIL post_reset_drain: got missing=%0d lvl=%0d, required 0 0",
                     exp_q.size(), cmd_if.cmd_level);
            exp_q.delete();
        end
    endtask

    initial begin
        cmd_if.cmd_ready = 1'b0;
        @(negedge clk_1ms);
        test_reset();
        test_single_press();
        test_auto_repeat();
        test_restart_no_repeat();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
